// File: rtl/alu_scheduler_pkg.sv
// Shared types for the ALU scheduler.
//   alu_op_e / alu_input : operation and operands handed to the multi-cycle ALU
//   alu_sched_state_e    : scheduler FSM states
//   alu_rsp              : response payload returned to the granted requester
//   ALU_SCHED_MAX_REQ    : largest supported requester count
package alu_scheduler_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_input;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RESPOND = 2'd2
  } alu_sched_state_e;

  typedef struct packed {
    logic [7:0] result;
    logic       overflow;
    logic       error;
  } alu_rsp;

  localparam int ALU_SCHED_MAX_REQ = 8;

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin arbiter for the ALU scheduler.
// Grants the first valid requester at or after the pointer, wrapping around.
// The pointer moves to one past the winner only when the grant is taken.
// Ports:
//   clk_in, rst_n_in : clock (rising edge) and asynchronous active-low reset
//   valid_in         : per-requester request valid
//   accept_in        : high when the current grant is being consumed
//   grant_out        : one-hot grant (zero when nothing is valid)
//   grant_idx_out    : index of the granted requester
//   any_out          : at least one requester is valid
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         valid_in,
  input  logic                       accept_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_out,
  output logic                       any_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] j;

  always_comb begin
    grant_out     = '0;
    grant_idx_out = '0;
    any_out       = 1'b0;
    sum           = '0;
    j             = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap ptr+i without a modulo so non-power-of-two counts stay cheap.
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      j = sum[IDX_W-1:0];
      if (!any_out && valid_in[j]) begin
        any_out       = 1'b1;
        grant_out[j]  = 1'b1;
        grant_idx_out = j;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_in && any_out) begin
      ptr_d = (grant_idx_out == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx_out + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_scheduler.sv
// ALU scheduler: shares one multi-cycle ALU between NUM_REQ requesters.
// Arbitrates round-robin, latches and holds the winner's operands, keeps the
// ALU in reset outside RUN, captures result/overflow on done and returns them
// over a per-requester valid/ready response channel.
// Optional feature: define ALU_SCHED_TIMEOUT_EN to abort RUN after
// TIMEOUT_CYCLES cycles without done (response with error=1, result=0).
// Ports:
//   clk_in, rst_n_in   : clock (rising edge), asynchronous active-low reset
//   req_valid_in       : per-requester request valid
//   req_data_in        : per-requester op and operands
//   req_ready_out      : one-hot single-cycle accept pulse
//   rsp_valid_out      : one-hot response valid to the granted requester
//   rsp_ready_in       : per-requester response ready
//   rsp_result_out     : captured ALU result
//   rsp_overflow_out   : captured ALU overflow
//   rsp_error_out      : timeout flag (0 unless ALU_SCHED_TIMEOUT_EN)
//   alu_rst_out        : active-high ALU reset, high whenever not in RUN
//   alu_in_out         : registered operands to the ALU
//   alu_result_in, alu_overflow_in, alu_done_in : ALU outputs
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic     [NUM_REQ-1:0]   req_valid_in,
  input  alu_input [NUM_REQ-1:0]   req_data_in,
  output logic     [NUM_REQ-1:0]   req_ready_out,
  output logic     [NUM_REQ-1:0]   rsp_valid_out,
  input  logic     [NUM_REQ-1:0]   rsp_ready_in,
  output logic     [7:0]           rsp_result_out,
  output logic                     rsp_overflow_out,
  output logic                     rsp_error_out,
  output logic                     alu_rst_out,
  output alu_input                 alu_in_out,
  input  logic     [7:0]           alu_result_in,
  input  logic                     alu_overflow_in,
  input  logic                     alu_done_in
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > ALU_SCHED_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("alu_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  alu_sched_state_e state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  alu_input         alu_in_q, alu_in_d;
  logic [7:0]       result_q, result_d;
  logic             overflow_q, overflow_d;
  alu_rsp           rsp;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               in_idle;

  assign in_idle = (state_q == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .valid_in      (req_valid_in),
    .accept_in     (in_idle),
    .grant_out     (arb_grant),
    .grant_idx_out (arb_idx),
    .any_out       (arb_any)
  );

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             error_q, error_d;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    alu_in_d   = alu_in_q;
    result_d   = result_q;
    overflow_d = overflow_q;
`ifdef ALU_SCHED_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    error_d    = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          alu_in_d  = req_data_in[arb_idx];
          gnt_d     = arb_idx;
          state_d   = RUN;
`ifdef ALU_SCHED_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      RUN: begin
        // done has priority over a timeout landing in the same cycle.
        if (alu_done_in) begin
          result_d   = alu_result_in;
          overflow_d = alu_overflow_in;
          state_d    = RESPOND;
`ifdef ALU_SCHED_TIMEOUT_EN
          error_d    = 1'b0;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d   = '0;
          overflow_d = 1'b0;
          error_d    = 1'b1;
          state_d    = RESPOND;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
`endif
        end
      end
      RESPOND: begin
        if (rsp_ready_in[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      alu_in_q   <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      alu_in_q   <= alu_in_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
`ifdef ALU_SCHED_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      error_q    <= error_d;
`endif
    end
  end

  always_comb begin
    rsp.result   = result_q;
    rsp.overflow = overflow_q;
`ifdef ALU_SCHED_TIMEOUT_EN
    rsp.error    = error_q;
`else
    rsp.error    = 1'b0;
`endif
  end

  always_comb begin
    rsp_valid_out = '0;
    if (state_q == RESPOND) rsp_valid_out[gnt_q] = 1'b1;
  end

  assign req_ready_out    = in_idle ? arb_grant : '0;
  assign rsp_result_out   = rsp.result;
  assign rsp_overflow_out = rsp.overflow;
  assign rsp_error_out    = rsp.error;
  assign alu_rst_out      = (state_q != RUN);
  assign alu_in_out       = alu_in_q;

endmodule
